// File: rtl/dec_scan_n.sv
// Registered IN_W-to-2^IN_W one-hot decoder with a scan sequencer.
// It supports direct, scan-up, scan-down and hold modes, with a programmable dwell.
module dec_scan_n #(
    parameter int IN_W  = 3,
    parameter int DWELL = 4,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic [IN_W-1:0]  idx,
    output logic             wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DWELL - 1);
    localparam logic [IN_W-1:0] IMAX = '1;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [CW-1:0]    cnt, cnt_next;
    logic [1:0]       prev_mode;
    logic [IN_W-1:0]  idx_next;
    logic [OUT_W-1:0] out_next;
    logic             wrap_next;
    logic             mode_chg;

    always_comb begin
        mode_chg  = (mode != prev_mode);
        idx_next  = idx;
        cnt_next  = cnt;
        wrap_next = 1'b0;
        if (en) begin
            case (mode)
                MODE_DIRECT: begin
                    idx_next = in;
                    cnt_next = '0;
                end
                MODE_HOLD: cnt_next = '0;
                default: begin
                    // A mode change takes priority over a coincident dwell expiry.
                    if (mode_chg) begin
                        cnt_next = '0;
                    end else if (cnt == LAST) begin
                        cnt_next = '0;
                        if (mode == MODE_UP) begin
                            idx_next  = idx + IN_W'(1);
                            wrap_next = (idx == IMAX);
                        end else begin
                            idx_next  = idx - IN_W'(1);
                            wrap_next = (idx == '0);
                        end
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            endcase
        end
        out_next = en ? (OUT_W'(1) << idx_next) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            cnt       <= '0;
            out       <= '0;
            wrap      <= 1'b0;
            prev_mode <= MODE_DIRECT;
        end else begin
            idx       <= idx_next;
            cnt       <= cnt_next;
            out       <= out_next;
            wrap      <= wrap_next;
            prev_mode <= mode;
        end
    end

endmodule

// File: tb/tb_dec_scan_n.sv
// Bench for dec_scan_n: vector table plus scoreboarded scan sequences for an 8-way instance,
// and a one-bit-per-cycle walk check for a 16-way DWELL=1 instance.
module tb_dec_scan_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  in = 3'd0;
    logic [7:0]  out;
    logic [2:0]  idx;
    logic        wrap;

    logic        en2 = 1'b0;
    logic [1:0]  mode2 = 2'b00;
    logic [3:0]  in2 = 4'd0;
    logic [15:0] out2;
    logic [3:0]  idx2;
    logic        wrap2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dec_scan_n #(.IN_W(3), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in),
        .out(out), .idx(idx), .wrap(wrap)
    );

    dec_scan_n #(.IN_W(4), .DWELL(1)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .mode(mode2), .in(in2),
        .out(out2), .idx(idx2), .wrap(wrap2)
    );

    typedef struct {
        logic [2:0] idx;
        logic [7:0] out;
        logic       wrap;
        string      name;
    } exp_t;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [2:0] in;
        logic [2:0] eidx;
        logic [7:0] eout;
        logic       ewrap;
    } vec_t;

    exp_t sb[$];

    // Reference state of the 8-way, DWELL=4 instance
    int m_idx = 0;
    int m_cnt = 0;
    int m_prev = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic exp_t model(input logic e, input logic [1:0] md, input logic [2:0] sel);
        exp_t x;
        bit chg;
        chg = (int'(md) != m_prev);
        m_prev = int'(md);
        x.wrap = 1'b0;
        if (e) begin
            if (md == 2'b00) begin
                m_idx = int'(sel);
                m_cnt = 0;
            end else if (md == 2'b11) begin
                m_cnt = 0;
            end else if (chg) begin
                m_cnt = 0;
            end else if (m_cnt == 3) begin
                m_cnt = 0;
                if (md == 2'b01) begin
                    x.wrap = (m_idx == 7);
                    m_idx = (m_idx + 1) % 8;
                end else begin
                    x.wrap = (m_idx == 0);
                    m_idx = (m_idx + 7) % 8;
                end
            end else begin
                m_cnt++;
            end
        end
        x.idx = 3'(m_idx);
        x.out = e ? (8'd1 << m_idx) : 8'd0;
        x.name = "model";
        return x;
    endfunction

    task automatic pop_cmp();
        exp_t x;
        x = sb.pop_front();
        chk({x.name, ".idx"}, 32'(idx), 32'(x.idx));
        chk({x.name, ".out"}, 32'(out), 32'(x.out));
        chk({x.name, ".wrap"}, 32'(wrap), 32'(x.wrap));
    endtask

    // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
    task automatic apply(input logic e, input logic [1:0] md, input logic [2:0] sel);
        en = e; mode = md; in = sel;
        sb.push_back(model(e, md, sel));
        @(posedge clk); #1;
        pop_cmp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_idx = 0; m_cnt = 0; m_prev = 0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vt[11];

    initial begin
        exp_t x;
        int n;
        logic [2:0] held;

        // Direct sweep from reset, then an en=0 cycle, then direct again
        for (int i = 0; i < 8; i++) vt[i] = '{1'b1, 2'b00, 3'(i), 3'(i), 8'd1 << i, 1'b0};
        vt[8]  = '{1'b0, 2'b00, 3'd3, 3'd7, 8'h00, 1'b0};
        vt[9]  = '{1'b1, 2'b00, 3'd6, 3'd6, 8'h40, 1'b0};
        vt[10] = '{1'b1, 2'b00, 3'd6, 3'd6, 8'h40, 1'b0};

        #2;
        chk("reset.out", 32'(out), 32'h0);
        chk("reset.idx", 32'(idx), 32'h0);
        chk("reset.wrap", 32'(wrap), 32'h0);
        do_reset();

        foreach (vt[i]) begin
            en = vt[i].en; mode = vt[i].mode; in = vt[i].in;
            x = model(vt[i].en, vt[i].mode, vt[i].in);
            x.idx = vt[i].eidx; x.out = vt[i].eout; x.wrap = vt[i].ewrap;
            x.name = $sformatf("vec%0d", i);
            sb.push_back(x);
            @(posedge clk); #1;
            pop_cmp();
        end

        // Scan up from idx=6: mode-change edge, then a step every 4 cycles
        for (int i = 1; i <= 9; i++) begin
            apply(1'b1, 2'b01, 3'd0);
            if (i == 5) chk("up.step7", 32'({idx, out, wrap}), 32'({3'd7, 8'h80, 1'b0}));
            if (i == 9) chk("up.wrap", 32'({idx, out, wrap}), 32'({3'd0, 8'h01, 1'b1}));
        end
        apply(1'b1, 2'b01, 3'd0);
        chk("up.wrap_once", 32'(wrap), 32'h0);

        // Scan down from idx=0 with an en pause mid-dwell
        m_cnt = m_cnt;
        for (int i = 1; i <= 5; i++) apply(1'b1, 2'b10, 3'd0);
        chk("down.wrap", 32'({idx, out, wrap}), 32'({3'd7, 8'h80, 1'b1}));
        apply(1'b1, 2'b10, 3'd0);
        apply(1'b1, 2'b10, 3'd0);
        for (int i = 0; i < 10; i++) apply(1'b0, 2'b10, 3'd5);
        chk("pause.frozen", 32'({idx, out}), 32'({3'd7, 8'h00}));
        apply(1'b1, 2'b10, 3'd0);
        apply(1'b1, 2'b10, 3'd0);
        chk("resume.step", 32'({idx, out}), 32'({3'd6, 8'h40}));

        // Mode change coinciding with dwell expiry: no step
        for (int i = 0; i < 4; i++) apply(1'b1, 2'b01, 3'd0);
        held = idx;
        apply(1'b1, 2'b11, 3'd0);
        chk("collide.nostep", 32'(idx), 32'(held));
        for (int i = 1; i <= 5; i++) begin
            apply(1'b1, 2'b01, 3'd0);
            if (i == 4) chk("collide.wait", 32'(idx), 32'(held));
        end
        chk("collide.step", 32'(idx), 32'(held + 3'd1));

        // Asynchronous reset while scanning at idx=5
        n = 0;
        while (idx != 3'd5 && n < 40) begin
            apply(1'b1, 2'b01, 3'd0);
            n++;
        end
        chk("reach5.timeout", 32'(idx), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async.out", 32'(out), 32'h0);
        chk("async.idx", 32'(idx), 32'h0);
        chk("async.wrap", 32'(wrap), 32'h0);
        m_idx = 0; m_cnt = 0; m_prev = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) apply(1'b1, 2'b01, 3'd0);
        chk("postreset.step", 32'({idx, out}), 32'({3'd1, 8'h02}));

        // 16-way, DWELL=1: one step per cycle after the mode-change edge
        en = 1'b0; mode = 2'b00;
        do_reset();
        en2 = 1'b1; mode2 = 2'b01;
        n = 0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            n = (k - 1) % 16;
            chk($sformatf("walk%0d.idx", k), 32'(idx2), 32'(n));
            chk($sformatf("walk%0d.out", k), 32'(out2), 32'(16'd1 << n));
            chk($sformatf("walk%0d.wrap", k), 32'(wrap2), 32'((k > 1) && (n == 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
